// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the MC-series program sequencer.
// Opcode/cond enums, register addresses and the instruction word layout.
package mc_pkg;

  localparam int INSTR_W = 28;

  localparam int COND_LSB = 26;
  localparam int COND_W   = 2;
  localparam int OP_LSB   = 22;
  localparam int OP_W     = 4;
  localparam int DST_LSB  = 19;
  localparam int SRC0_LSB = 16;
  localparam int SRC1_LSB = 13;
  localparam int REG_W    = 3;
  localparam int ISEL_BIT = 12;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 11;

  localparam logic [REG_W-1:0] REG_ACC  = 3'b000;
  localparam logic [REG_W-1:0] REG_P0   = 3'b010;
  localparam logic [REG_W-1:0] REG_P1   = 3'b011;
  localparam logic [REG_W-1:0] REG_X0   = 3'b100;
  localparam logic [REG_W-1:0] REG_X1   = 3'b101;
  localparam logic [REG_W-1:0] REG_NONE = 3'b111;

  typedef enum logic [COND_W-1:0] {
    C_ALW   = 2'b00,
    C_PLUS  = 2'b01,
    C_MINUS = 2'b10,
    C_ONCE  = 2'b11
  } cond_e;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_NOT = 4'd5,
    OP_DGT = 4'd6,
    OP_DST = 4'd7,
    OP_TEQ = 4'd8,
    OP_TGT = 4'd9,
    OP_TLT = 4'd10,
    OP_TCP = 4'd11,
    OP_JMP = 4'd12,
    OP_SLP = 4'd13
  } op_e;

  // bit 11 of the word is reserved
  typedef struct packed {
    cond_e            cond;
    op_e              op;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src0;
    logic [REG_W-1:0] src1;
    logic             isel;
    logic             rsvd;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic is_xreg(
    input logic [REG_W-1:0] r
  );
    return (r == REG_X0) || (r == REG_X1);
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: register-file control bus between sequencer and
// register file, with the increment_pc handshake back.
interface mc_sequencer_if;
  import mc_pkg::*;

  logic                 write_en;
  logic [REG_W-1:0]     write_addr;
  logic [REG_W-1:0]     read_addr0;
  logic [REG_W-1:0]     read_addr1;
  logic [OP_W-1:0]      alu_op;
  logic [IMM_W-1:0]     imm;
  logic                 imm_sel;
  logic                 increment_pc;

  modport master (
    output write_en, write_addr,
    output read_addr0, read_addr1,
    output alu_op, imm, imm_sel,
    input  increment_pc
  );

  modport slave (
    input  write_en, write_addr,
    input  read_addr0, read_addr1,
    input  alu_op, imm, imm_sel,
    output increment_pc
  );

endinterface

// File: rtl/mc_sleep_timer.sv
// mc_sleep_timer: 11-bit sleep counter, loaded by slp and decremented
// on time_tick; done flags the tick that brings it to zero.
module mc_sleep_timer
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IMM_W-1:0] load_val,
  input  logic             time_tick,
  output logic             done
);

  logic [IMM_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (time_tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = time_tick && !load
              && (cnt == IMM_W'(1));

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: PC, decode, conditional execution and slp for one core.
// Define MC_ONCE_EN to build the per-line once-register for '@' lines.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int PROG_DEPTH = 14,
  parameter int PC_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    last_line,
  input  logic               test_plus,
  input  logic               test_minus,
  input  logic               time_tick,
  output logic [PC_W-1:0]    pc,
  output logic               sleeping,
  mc_sequencer_if.master     rf
);

  typedef enum logic {RUN, SLEEP} state_e;

  state_e         state;
  instr_t         ins;
  logic           plus_en, minus_en;
  logic           is_data, is_test;
  logic           is_jmp, is_slp;
  logic           exec, live, once_hit;
  logic           stall, slp_go, wake;
  logic [PC_W-1:0] pc_adv, pc_jmp;
  logic           unused_rsvd;

  assign ins         = instr_t'(instr);
  assign unused_rsvd = ins.rsvd;

`ifdef MC_ONCE_EN
  logic [PROG_DEPTH-1:0] once_q;

  assign once_hit = once_q[pc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      once_q <= '0;
    end else if (state == RUN && exec
                 && ins.cond == C_ONCE
                 && !stall) begin
      once_q[pc] <= 1'b1;
    end
  end
`else
  assign once_hit = 1'b0;
`endif

  always_comb begin
    exec = 1'b0;
    unique case (ins.cond)
      C_ALW:   exec = 1'b1;
      C_PLUS:  exec = plus_en;
      C_MINUS: exec = minus_en;
      C_ONCE:  exec = !once_hit;
    endcase
  end

  always_comb begin
    is_data = 1'b0;
    is_test = 1'b0;
    is_jmp  = 1'b0;
    is_slp  = 1'b0;
    unique case (ins.op)
      OP_TEQ, OP_TGT,
      OP_TLT, OP_TCP: is_test = 1'b1;
      OP_JMP:         is_jmp  = 1'b1;
      OP_SLP:         is_slp  = 1'b1;
      default:        is_data = 1'b1;
    endcase
  end

  assign live = rst_n && state == RUN && exec;

  assign stall = live && is_data
    && !rf.increment_pc
    && (is_xreg(ins.dst) || is_xreg(ins.src0)
        || is_xreg(ins.src1));

  // imm is signed here: negative or zero means no sleep
  assign slp_go = is_slp && !ins.imm[IMM_W-1]
                && ins.imm != '0;

  assign pc_adv =
    (pc == last_line || pc == PC_W'(PROG_DEPTH-1))
      ? '0 : pc + 1'b1;

  assign pc_jmp = (int'(ins.imm) >= PROG_DEPTH)
                ? '0 : ins.imm[PC_W-1:0];

  always_comb begin
    rf.write_en   = 1'b0;
    rf.write_addr = REG_NONE;
    rf.read_addr0 = REG_NONE;
    rf.read_addr1 = REG_NONE;
    rf.alu_op     = OP_NOP;
    rf.imm        = '0;
    rf.imm_sel    = 1'b0;
    unique case (1'b1)
      !live: ;
      live && is_data: begin
        rf.write_en   = ins.dst != REG_NONE;
        rf.write_addr = ins.dst;
        rf.read_addr0 = ins.src0;
        rf.read_addr1 = ins.src1;
        rf.alu_op     = ins.op;
        rf.imm        = ins.imm;
        rf.imm_sel    = ins.isel;
      end
      live && !is_data: begin
        rf.read_addr0 = ins.src0;
        rf.read_addr1 = ins.src1;
        rf.alu_op     = ins.op;
        rf.imm        = ins.imm;
        rf.imm_sel    = ins.isel;
      end
    endcase
  end

  mc_sleep_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (live && is_slp && slp_go),
    .load_val  (ins.imm),
    .time_tick (time_tick),
    .done      (wake)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= '0;
      plus_en  <= 1'b0;
      minus_en <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!exec) begin
            pc <= pc_adv;
          end else if (is_jmp) begin
            pc <= pc_jmp;
          end else if (is_slp && slp_go) begin
            state <= SLEEP;
          end else if (!stall) begin
            pc <= pc_adv;
            if (is_test) begin
              plus_en  <= test_plus;
              minus_en <= test_minus;
            end
          end
        end
        SLEEP: begin
          if (wake) begin
            state <= RUN;
            pc    <= pc_adv;
          end
        end
      endcase
    end
  end

  assign sleeping = (state == SLEEP);

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed checks of the mc_sequencer program flow.
// Honours MC_ONCE_EN the same way as the design.
module tb_mc_sequencer;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] instr;
  logic [3:0]  last_line = 4'd0;
  logic        test_plus = 1'b0;
  logic        test_minus = 1'b0;
  logic        time_tick = 1'b0;
  logic [3:0]  pc;
  logic        sleeping;
  logic [27:0] rom [16];
  int          total = 0;
  int          bad = 0;

  mc_sequencer_if rf();

  mc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .last_line  (last_line),
    .test_plus  (test_plus),
    .test_minus (test_minus),
    .time_tick  (time_tick),
    .pc         (pc),
    .sleeping   (sleeping),
    .rf         (rf)
  );

  always #5 clk = ~clk;

  assign instr = rom[pc];

  function automatic logic [27:0] mk(
    input logic [1:0]  c,
    input logic [3:0]  op,
    input logic [2:0]  d,
    input logic [2:0]  s0,
    input logic [2:0]  s1,
    input logic        is,
    input logic [10:0] im
  );
    return {c, op, d, s0, s1, is, 1'b0, im};
  endfunction

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 28'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = mk(2'b00, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd5);
    rf.increment_pc = 1'b0;
    nxt();
    nxt();
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", pc); end
    total++; if (rf.write_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", rf.write_en); end
    total++; if (rf.write_addr !== 3'b111) begin bad++; $display("FAIL rst_wa got=%0b want=111", rf.write_addr); end
    total++; if (rf.read_addr0 !== 3'b111 || rf.read_addr1 !== 3'b111) begin bad++; $display("FAIL rst_ra got=%0b/%0b want=111/111", rf.read_addr0, rf.read_addr1); end
    total++; if (rf.alu_op !== 4'd0 || rf.imm !== 11'd0 || rf.imm_sel !== 1'b0) begin bad++; $display("FAIL rst_op got=%0d/%0d/%0b want=0/0/0", rf.alu_op, rf.imm, rf.imm_sel); end
    total++; if (sleeping !== 1'b0) begin bad++; $display("FAIL rst_sleep got=%0b want=0", sleeping); end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = mk(2'b00, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd5);
    rom[1] = mk(2'b00, OP_ADD, 3'b000, 3'b111, 3'b000, 1'b1, 11'd3);
    last_line = 4'd1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (pc !== 4'(i % 2)) begin bad++; $display("FAIL wrap_pc got=%0d want=%0d", pc, i % 2); end
      total++; if (rf.write_en !== 1'b1 || rf.write_addr !== 3'b000) begin bad++; $display("FAIL wrap_we got=%0b/%0b want=1/000", rf.write_en, rf.write_addr); end
      total++; if (rf.alu_op !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin bad++; $display("FAIL wrap_op got=%0d want=%0d", rf.alu_op, (i % 2 == 0) ? 1 : 2); end
      nxt();
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[0] = mk(2'b00, OP_MOV, 3'b100, 3'b000, 3'b111, 1'b0, 11'd0);
    rom[1] = mk(2'b00, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd1);
    last_line = 4'd1;
    rf.increment_pc = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (pc !== 4'd0) begin bad++; $display("FAIL stall_pc cyc=%0d got=%0d want=0", i, pc); end
      total++; if (rf.write_en !== 1'b1 || rf.write_addr !== 3'b100 || rf.read_addr0 !== 3'b000 || rf.alu_op !== 4'd1) begin bad++; $display("FAIL stall_out cyc=%0d got=%0b/%0b/%0b/%0d want=1/100/000/1", i, rf.write_en, rf.write_addr, rf.read_addr0, rf.alu_op); end
      if (i < 3) nxt();
    end
    rf.increment_pc = 1'b1;
    nxt();
    rf.increment_pc = 1'b0;
    total++; if (pc !== 4'd1) begin bad++; $display("FAIL stall_adv got=%0d want=1", pc); end
    total++; if (rf.write_addr !== 3'b000) begin bad++; $display("FAIL stall_next_wa got=%0b want=000", rf.write_addr); end
  endtask

  task automatic test_cond();
    clear_rom();
    rom[0] = mk(2'b00, OP_TEQ, 3'b111, 3'b000, 3'b010, 1'b0, 11'd0);
    rom[1] = mk(2'b01, OP_MOV, 3'b010, 3'b111, 3'b111, 1'b1, 11'd1);
    rom[2] = mk(2'b10, OP_MOV, 3'b010, 3'b111, 3'b111, 1'b1, 11'd2);
    rom[3] = mk(2'b00, OP_NOP, 3'b111, 3'b111, 3'b111, 1'b0, 11'd0);
    last_line = 4'd3;
    test_plus = 1'b1;
    test_minus = 1'b0;
    do_reset();
    total++; if (rf.write_en !== 1'b0) begin bad++; $display("FAIL teq_we got=%0b want=0", rf.write_en); end
    nxt();
    total++; if (rf.write_en !== 1'b1 || rf.write_addr !== 3'b010 || rf.imm !== 11'd1) begin bad++; $display("FAIL plus_exec got=%0b/%0b/%0d want=1/010/1", rf.write_en, rf.write_addr, rf.imm); end
    nxt();
    total++; if (rf.write_en !== 1'b0 || pc !== 4'd2) begin bad++; $display("FAIL minus_skip got=%0b/%0d want=0/2", rf.write_en, pc); end
    nxt();
    total++; if (pc !== 4'd3) begin bad++; $display("FAIL skip_adv got=%0d want=3", pc); end
    nxt();
    test_plus = 1'b0;
    test_minus = 1'b1;
    nxt();
    total++; if (rf.write_en !== 1'b0 || pc !== 4'd1) begin bad++; $display("FAIL plus_skip got=%0b/%0d want=0/1", rf.write_en, pc); end
    nxt();
    total++; if (rf.write_en !== 1'b1 || rf.imm !== 11'd2) begin bad++; $display("FAIL minus_exec got=%0b/%0d want=1/2", rf.write_en, rf.imm); end
  endtask

  task automatic test_sleep();
    clear_rom();
    rom[0] = mk(2'b00, OP_SLP, 3'b111, 3'b111, 3'b111, 1'b1, 11'd3);
    rom[1] = mk(2'b00, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd1);
    rom[2] = mk(2'b00, OP_SLP, 3'b111, 3'b111, 3'b111, 1'b1, 11'd0);
    rom[3] = mk(2'b00, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd2);
    last_line = 4'd3;
    time_tick = 1'b0;
    do_reset();
    time_tick = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      nxt();
      total++; if (sleeping !== 1'b1 || pc !== 4'd0) begin bad++; $display("FAIL slp_hold cyc=%0d got=%0b/%0d want=1/0", c, sleeping, pc); end
      if (c == 15) begin
        total++; if (rf.write_en !== 1'b0 || rf.read_addr0 !== 3'b111 || rf.read_addr1 !== 3'b111) begin bad++; $display("FAIL slp_bus got=%0b/%0b/%0b want=0/111/111", rf.write_en, rf.read_addr0, rf.read_addr1); end
      end
      time_tick = (c % 10 == 0);
    end
    nxt();
    time_tick = 1'b0;
    total++; if (sleeping !== 1'b0 || pc !== 4'd1) begin bad++; $display("FAIL slp_wake got=%0b/%0d want=0/1", sleeping, pc); end
    nxt();
    total++; if (sleeping !== 1'b0 || pc !== 4'd2) begin bad++; $display("FAIL slp0_issue got=%0b/%0d want=0/2", sleeping, pc); end
    nxt();
    total++; if (sleeping !== 1'b0 || pc !== 4'd3) begin bad++; $display("FAIL slp0_adv got=%0b/%0d want=0/3", sleeping, pc); end
  endtask

  task automatic test_once();
    logic exp_we;
`ifdef MC_ONCE_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    clear_rom();
    rom[0] = mk(2'b11, OP_MOV, 3'b000, 3'b111, 3'b111, 1'b1, 11'd7);
    rom[1] = mk(2'b00, OP_MOV, 3'b010, 3'b111, 3'b111, 1'b1, 11'd1);
    last_line = 4'd1;
    do_reset();
    total++; if (rf.write_en !== 1'b1 || rf.imm !== 11'd7) begin bad++; $display("FAIL once_first got=%0b/%0d want=1/7", rf.write_en, rf.imm); end
    for (int p = 0; p < 2; p++) begin
      nxt();
      nxt();
      total++; if (pc !== 4'd0 || rf.write_en !== exp_we) begin bad++; $display("FAIL once_pass%0d got=%0d/%0b want=0/%0b", p, pc, rf.write_en, exp_we); end
    end
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[0]  = mk(2'b00, OP_JMP, 3'b111, 3'b111, 3'b111, 1'b1, 11'd12);
    rom[12] = mk(2'b00, OP_NOP, 3'b111, 3'b111, 3'b111, 1'b0, 11'd0);
    rom[13] = mk(2'b00, OP_NOP, 3'b111, 3'b111, 3'b111, 1'b0, 11'd0);
    last_line = 4'd15;
    do_reset();
    nxt();
    total++; if (pc !== 4'd12) begin bad++; $display("FAIL jmp_tgt got=%0d want=12", pc); end
    nxt();
    nxt();
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL depth_wrap got=%0d want=0", pc); end
    rom[12] = mk(2'b00, OP_JMP, 3'b111, 3'b111, 3'b111, 1'b1, 11'd14);
    nxt();
    nxt();
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL jmp_range got=%0d want=0", pc); end
  endtask

  task automatic test_reset_sleep();
    clear_rom();
    rom[0] = mk(2'b00, OP_TEQ, 3'b111, 3'b000, 3'b010, 1'b0, 11'd0);
    rom[1] = mk(2'b00, OP_SLP, 3'b111, 3'b111, 3'b111, 1'b1, 11'd5);
    last_line = 4'd1;
    test_plus = 1'b1;
    test_minus = 1'b1;
    time_tick = 1'b0;
    do_reset();
    nxt();
    nxt();
    total++; if (sleeping !== 1'b1 || pc !== 4'd1) begin bad++; $display("FAIL rs_sleep got=%0b/%0d want=1/1", sleeping, pc); end
    rst_n = 1'b0;
    #1;
    total++; if (pc !== 4'd0 || sleeping !== 1'b0) begin bad++; $display("FAIL rs_async got=%0d/%0b want=0/0", pc, sleeping); end
    rom[0] = mk(2'b01, OP_MOV, 3'b010, 3'b111, 3'b111, 1'b1, 11'd1);
    rom[1] = mk(2'b10, OP_MOV, 3'b010, 3'b111, 3'b111, 1'b1, 11'd2);
    nxt();
    rst_n = 1'b1;
    #1;
    total++; if (rf.write_en !== 1'b0) begin bad++; $display("FAIL rs_plus_clr got=%0b want=0", rf.write_en); end
    nxt();
    total++; if (rf.write_en !== 1'b0 || pc !== 4'd1) begin bad++; $display("FAIL rs_minus_clr got=%0b/%0d want=0/1", rf.write_en, pc); end
  endtask

  initial begin
    rf.increment_pc = 1'b0;
    test_reset();
    test_wrap();
    test_stall();
    test_cond();
    test_sleep();
    test_once();
    test_jmp();
    test_reset_sleep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
